// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction-fetch queue: default widths, depth,
// reset PC and the fixed instruction size.
package ifetch_queue_pkg;
  localparam int          A_WIDTH_DEF  = 32;
  localparam int          D_WIDTH_DEF  = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous flush and an occupancy count.
// Flush clears pointers and count only; storage is cleared by rst alone.
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int W     = A_WIDTH_DEF + D_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch front end: sequential fetch address generation into a
// 1-cycle synchronous imem, with returned words queued alongside their PC.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                 A_WIDTH  = A_WIDTH_DEF,
  parameter int                 D_WIDTH  = D_WIDTH_DEF,
  parameter int                 DEPTH    = DEPTH_DEF,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [A_WIDTH-1:0]     imem_addr,
  input  logic [D_WIDTH-1:0]     imem_rdata,
  input  logic                   redirect_valid,
  input  logic [A_WIDTH-1:0]     redirect_pc,
  input  logic                   dec_ready,
  output logic                   instr_valid,
  output logic [D_WIDTH-1:0]     instr_out,
  output logic [A_WIDTH-1:0]     pc_out,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [A_WIDTH-1:0] req_pc_q, req_pc_d;
  logic               resp_pending_q, resp_pending_d;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic               issue, push, pop;
  logic [A_WIDTH+D_WIDTH-1:0] head;

  // Credit the in-flight response so the queue can never be overrun;
  // a same-cycle dequeue is deliberately not counted as free space.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, resp_pending_q};
  assign issue     = !rst && !redirect_valid && (occupancy < DEPTH_W);

  // Decode handshake: a word transfers on a cycle where instr_valid && dec_ready.
  // instr_valid never depends on dec_ready; a redirect suppresses it.
  assign instr_valid = (count != '0) && !redirect_valid;
  assign pop         = instr_valid && dec_ready;
  assign push        = resp_pending_q && !redirect_valid;

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    resp_pending_d = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~A_WIDTH'(INSTR_BYTES - 1);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + A_WIDTH'(INSTR_BYTES);
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      resp_pending_q <= resp_pending_d;
    end
  end

  fetch_fifo #(
    .W     (A_WIDTH + D_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc_q, imem_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign pc_out    = head[A_WIDTH+D_WIDTH-1:D_WIDTH];
  assign instr_out = head[D_WIDTH-1:0];
  assign q_count   = count;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a vector table of per-cycle inputs and
// expected outputs, plus hand sequences for redirect latency, drain and PC wrap.
module tb_ifetch_queue;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst, redirect_valid, dec_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
  logic [2:0]  q_count;

  logic        w_rst, w_redirect_valid, w_dec_ready;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr_out, w_pc_out;
  logic [2:0]  w_q_count;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ifetch_queue u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_ready(dec_ready), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_out(pc_out), .q_count(q_count)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .dec_ready(w_dec_ready), .instr_valid(w_instr_valid),
    .instr_out(w_instr_out), .pc_out(w_pc_out), .q_count(w_q_count)
  );

  // instruction memory: word at address a is a ^ MASK, one cycle latency
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? (imem_addr ^ MASK)   : 32'hDEAD_BEEF;
    w_imem_rdata <= w_imem_req ? (w_imem_addr ^ MASK) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy,
                              logic req, logic [31:0] addr, logic valid,
                              logic [31:0] pc, logic [2:0] cnt);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = req; v.e_addr = addr; v.e_valid = valid;
    v.e_pc = r ? 32'h0 : pc;
    v.e_instr = r ? 32'h0 : (pc ^ MASK);
    v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_vectors();
    // reset, then streaming with dec_ready = 1
    vecs.push_back(mk(1,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,4,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,8,1,0,1));
    vecs.push_back(mk(0,0,0,1, 1,12,1,4,1));
    vecs.push_back(mk(0,0,0,1, 1,16,1,8,1));
    vecs.push_back(mk(0,0,0,1, 1,20,1,12,1));
    // stall ten cycles from reset: fill to DEPTH, then release
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,4,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,8,1,0,1));
    vecs.push_back(mk(0,0,0,0, 1,12,1,0,2));
    vecs.push_back(mk(0,0,0,0, 0,16,1,0,3));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0, 0,16,1,0,4));
    vecs.push_back(mk(0,0,0,1, 0,16,1,0,4));
    vecs.push_back(mk(0,0,0,1, 1,16,1,4,3));
    vecs.push_back(mk(0,0,0,1, 1,20,1,8,2));
    vecs.push_back(mk(0,0,0,1, 1,24,1,12,2));
    vecs.push_back(mk(0,0,0,1, 1,28,1,16,2));
    // redirect to 0x100 with three entries queued
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,4,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,8,1,0,1));
    vecs.push_back(mk(0,0,0,0, 1,12,1,0,2));
    vecs.push_back(mk(0,1,32'h100,1, 0,16,0,0,3));
    vecs.push_back(mk(0,0,0,1, 1,32'h100,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h104,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h108,1,32'h100,1));
    vecs.push_back(mk(0,0,0,1, 1,32'h10C,1,32'h104,1));
    // misaligned redirect target
    vecs.push_back(mk(0,1,32'h103,1, 0,32'h110,0,0,1));
    vecs.push_back(mk(0,0,0,1, 1,32'h100,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h104,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h108,1,32'h100,1));
    // back-to-back redirects
    vecs.push_back(mk(0,1,32'h200,1, 0,32'h10C,0,0,1));
    vecs.push_back(mk(0,1,32'h300,1, 0,32'h200,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h300,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h304,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,32'h308,1,32'h300,1));
    vecs.push_back(mk(0,0,0,1, 1,32'h30C,1,32'h304,1));
    // reset mid-stream, between clock edges
    vecs.push_back(mk(1,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,4,0,0,0));
    vecs.push_back(mk(0,0,0,1, 1,8,1,0,1));
    vecs.push_back(mk(0,0,0,1, 1,12,1,4,1));
  endtask

  initial begin
    int lat;
    int xfers;
    logic [31:0] exp_pc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    w_rst = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_dec_ready = 1'b1;
    fill_vectors();

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; redirect_valid = vecs[k].rv;
      redirect_pc = vecs[k].rpc; dec_ready = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d imem_req", k),    32'(imem_req),    32'(vecs[k].e_req));
      chk($sformatf("v%0d imem_addr", k),   imem_addr,        vecs[k].e_addr);
      chk($sformatf("v%0d instr_valid", k), 32'(instr_valid), 32'(vecs[k].e_valid));
      chk($sformatf("v%0d q_count", k),     32'(q_count),     32'(vecs[k].e_cnt));
      if (vecs[k].rst || vecs[k].e_valid) begin
        chk($sformatf("v%0d pc_out", k),    pc_out,    vecs[k].e_pc);
        chk($sformatf("v%0d instr_out", k), instr_out, vecs[k].e_instr);
      end
    end

    // redirect latency: target at head three cycles after the redirect
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h400; dec_ready = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      if (instr_valid) begin
        lat = c;
        break;
      end
    end
    chk("redirect_latency", 32'(lat), 32'd3);
    chk("redirect_head_pc", pc_out, 32'h400);

    // drain with a fixed stall pattern; PCs must be gapless and in order
    exp_pc = 32'h404;
    xfers = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dec_ready = (i % 3) != 2;
      #1;
      if (q_count > 3'd4) chk("drain_count_bound", 32'(q_count), 32'd4);
      if (instr_valid && dec_ready) begin
        chk($sformatf("drain%0d pc_out", i), pc_out, exp_pc);
        chk($sformatf("drain%0d instr_out", i), instr_out, exp_pc ^ MASK);
        exp_pc += 32'd4;
        xfers++;
      end
    end
    chk("drain_enough_xfers", 32'(xfers >= 20), 32'd1);

    // PC wrap from RESET_PC = 0xFFFFFFF8
    @(negedge clk);
    #1;
    chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFF8);
    chk("wrap_reset_req", 32'(w_imem_req), 32'd0);
    @(negedge clk);
    w_rst = 1'b0;
    #1;
    chk("wrap_c0_addr", w_imem_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_c1_addr", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_c2_addr", w_imem_addr, 32'h0000_0000);
    chk("wrap_c2_valid", 32'(w_instr_valid), 32'd1);
    chk("wrap_c2_pc", w_pc_out, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_c3_pc", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap_c3_instr", w_instr_out, 32'hFFFF_FFFC ^ MASK);
    @(negedge clk); #1;
    chk("wrap_c4_pc", w_pc_out, 32'h0000_0000);
    chk("wrap_c4_addr", w_imem_addr, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
